// File: rtl/axis_register_pkg.sv
// Shared definitions for the AXI-Stream register/skid chain: the per-stage
// state encoding, the legal range of the stage count, and the sideband port
// width helper.
package axis_register_pkg;

  // Per-stage occupancy state. RESET_ST is held for one cycle after reset
  // release so that neither side handshakes while the chain comes up.
  typedef enum logic [1:0] {
    RESET_ST = 2'd0,
    EMPTY_ST = 2'd1,
    ONE_ST   = 2'd2,
    TWO_ST   = 2'd3
  } stage_state_e;

  // Legal range of the cascaded stage count.
  localparam int STAGES_MIN = 0;
  localparam int STAGES_MAX = 16;

  // TUSER ports keep at least one bit even when no sideband is carried.
  function automatic int user_port_width(input int user_width);
    return (user_width > 0) ? user_width : 1;
  endfunction

endpackage

// File: rtl/axis_skid_stage.sv
// One register/skid stage: holds up to two beats (output register plus skid
// register). Both handshake outputs decode the state register only, so the
// downstream ready never reaches the upstream ready combinationally.
module axis_skid_stage
  import axis_register_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int USER_WIDTH = 8
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic [BYTE_WIDTH*8-1:0]                i_tdata,
  input  logic [BYTE_WIDTH-1:0]                  i_tkeep,
  input  logic [user_port_width(USER_WIDTH)-1:0] i_tuser,
  input  logic                                   i_tlast,
  input  logic                                   i_tvalid,
  output logic                                   o_tready,
  output logic [BYTE_WIDTH*8-1:0]                o_tdata,
  output logic [BYTE_WIDTH-1:0]                  o_tkeep,
  output logic [user_port_width(USER_WIDTH)-1:0] o_tuser,
  output logic                                   o_tlast,
  output logic                                   o_tvalid,
  input  logic                                   i_tready
);

  localparam int DATA_W    = BYTE_WIDTH * 8;
  localparam int USTORE_W  = (USER_WIDTH > 0) ? USER_WIDTH : 0;
  localparam int PAY_W     = DATA_W + BYTE_WIDTH + USTORE_W + 1;

  stage_state_e r_state;
  stage_state_e w_state_nxt;

  logic             w_ready;
  logic             w_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_oreg_in;
  logic             w_load_oreg_skid;
  logic             w_load_sreg;
  logic [PAY_W-1:0] w_in_pay;

  // Payload is kept in discrete flops so it is never packed into shift-register
  // primitives; it is deliberately not reset.
  (* shreg_extract = "no" *) logic [PAY_W-1:0] r_oreg;
  (* shreg_extract = "no" *) logic [PAY_W-1:0] r_sreg;

  // Beat packing: TUSER is stored only when the sideband exists.
  if (USER_WIDTH > 0) begin : g_user
    assign w_in_pay = {i_tdata, i_tkeep, i_tuser, i_tlast};
    assign o_tuser  = r_oreg[USER_WIDTH:1];
  end else begin : g_no_user
    logic w_unused_tuser;
    assign w_unused_tuser = i_tuser[0];
    assign w_in_pay       = {i_tdata, i_tkeep, i_tlast};
    assign o_tuser        = 1'b0;
  end

  assign o_tdata = r_oreg[PAY_W-1 -: DATA_W];
  assign o_tkeep = r_oreg[PAY_W-1-DATA_W -: BYTE_WIDTH];
  assign o_tlast = r_oreg[0];

  assign w_valid    = (r_state == ONE_ST) || (r_state == TWO_ST);
  assign w_ready    = (r_state == EMPTY_ST) || (r_state == ONE_ST);
  assign o_tvalid   = w_valid;
  assign o_tready   = w_ready;
  assign w_in_fire  = i_tvalid & w_ready;
  assign w_out_fire = w_valid & i_tready;

  // Next-state and payload load selection from the two handshakes.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_oreg_in   = 1'b0;
    w_load_oreg_skid = 1'b0;
    w_load_sreg      = 1'b0;
    case (r_state)
      RESET_ST: begin
        w_state_nxt = EMPTY_ST;
      end
      EMPTY_ST: begin
        if (w_in_fire) begin
          w_load_oreg_in = 1'b1;
          w_state_nxt    = ONE_ST;
        end else begin
          w_state_nxt = EMPTY_ST;
        end
      end
      ONE_ST: begin
        if (w_in_fire && w_out_fire) begin
          w_load_oreg_in = 1'b1;
          w_state_nxt    = ONE_ST;
        end else if (w_in_fire) begin
          w_load_sreg = 1'b1;
          w_state_nxt = TWO_ST;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY_ST;
        end else begin
          w_state_nxt = ONE_ST;
        end
      end
      TWO_ST: begin
        if (w_out_fire) begin
          w_load_oreg_skid = 1'b1;
          w_state_nxt      = ONE_ST;
        end else begin
          w_state_nxt = TWO_ST;
        end
      end
      default: begin
        w_state_nxt = RESET_ST;
      end
    endcase
  end

  // State register; reset discards any held beats.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= RESET_ST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload registers: output register takes new input or the skid contents.
  always_ff @(posedge CLK) begin
    if (w_load_oreg_in) begin
      r_oreg <= w_in_pay;
    end else if (w_load_oreg_skid) begin
      r_oreg <= r_sreg;
    end
    if (w_load_sreg) begin
      r_sreg <= w_in_pay;
    end
  end

endmodule

// File: rtl/axis_register_skid_chain.sv
// Cascade of STAGES register/skid stages on an AXI-Stream path. STAGES = 0
// degenerates to a combinational pass-through that ignores reset.
module axis_register_skid_chain
  import axis_register_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int USER_WIDTH = 8,
  parameter int STAGES     = 1
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic [BYTE_WIDTH*8-1:0]                S_AXIS_TDATA,
  input  logic [BYTE_WIDTH-1:0]                  S_AXIS_TKEEP,
  input  logic [user_port_width(USER_WIDTH)-1:0] S_AXIS_TUSER,
  input  logic                                   S_AXIS_TVALID,
  output logic                                   S_AXIS_TREADY,
  input  logic                                   S_AXIS_TLAST,
  output logic [BYTE_WIDTH*8-1:0]                M_AXIS_TDATA,
  output logic [BYTE_WIDTH-1:0]                  M_AXIS_TKEEP,
  output logic [user_port_width(USER_WIDTH)-1:0] M_AXIS_TUSER,
  output logic                                   M_AXIS_TVALID,
  input  logic                                   M_AXIS_TREADY,
  output logic                                   M_AXIS_TLAST
);

  localparam int DATA_W  = BYTE_WIDTH * 8;
  localparam int UPORT_W = user_port_width(USER_WIDTH);

  if (STAGES == 0) begin : g_bypass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = CLK ^ RESET;
    assign M_AXIS_TDATA     = S_AXIS_TDATA;
    assign M_AXIS_TKEEP     = S_AXIS_TKEEP;
    assign M_AXIS_TLAST     = S_AXIS_TLAST;
    assign M_AXIS_TVALID    = S_AXIS_TVALID;
    assign S_AXIS_TREADY    = M_AXIS_TREADY;
    if (USER_WIDTH > 0) begin : g_byp_user
      assign M_AXIS_TUSER = S_AXIS_TUSER;
    end else begin : g_byp_no_user
      logic w_unused_tuser;
      assign w_unused_tuser = S_AXIS_TUSER[0];
      assign M_AXIS_TUSER   = {UPORT_W{1'b0}};
    end
  end else begin : g_chain
    // Index g is the input of stage g; index STAGES is the block output.
    logic [DATA_W-1:0]     w_data  [0:STAGES];
    logic [BYTE_WIDTH-1:0] w_keep  [0:STAGES];
    logic [UPORT_W-1:0]    w_user  [0:STAGES];
    logic                  w_last  [0:STAGES];
    logic                  w_valid [0:STAGES];
    logic                  w_ready [0:STAGES];

    assign w_data[0]       = S_AXIS_TDATA;
    assign w_keep[0]       = S_AXIS_TKEEP;
    assign w_user[0]       = S_AXIS_TUSER;
    assign w_last[0]       = S_AXIS_TLAST;
    assign w_valid[0]      = S_AXIS_TVALID;
    assign S_AXIS_TREADY   = w_ready[0];

    assign M_AXIS_TDATA    = w_data[STAGES];
    assign M_AXIS_TKEEP    = w_keep[STAGES];
    assign M_AXIS_TUSER    = w_user[STAGES];
    assign M_AXIS_TLAST    = w_last[STAGES];
    assign M_AXIS_TVALID   = w_valid[STAGES];
    assign w_ready[STAGES] = M_AXIS_TREADY;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      axis_skid_stage #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .USER_WIDTH (USER_WIDTH)
      ) u_stage (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_tdata  (w_data[g]),
        .i_tkeep  (w_keep[g]),
        .i_tuser  (w_user[g]),
        .i_tlast  (w_last[g]),
        .i_tvalid (w_valid[g]),
        .o_tready (w_ready[g]),
        .o_tdata  (w_data[g+1]),
        .o_tkeep  (w_keep[g+1]),
        .o_tuser  (w_user[g+1]),
        .o_tlast  (w_last[g+1]),
        .o_tvalid (w_valid[g+1]),
        .i_tready (w_ready[g+1])
      );
    end
  end

endmodule

// File: tb/tb_axis_register_skid_chain.sv
// Directed bench: five registered chains (STAGES = 1..5, 8-byte data, 8-bit
// user) plus one pass-through chain (STAGES = 0, 1 byte, no user).
module tb_axis_register_skid_chain;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] s_data  [NI];
  logic [7:0]  s_keep  [NI];
  logic [7:0]  s_user  [NI];
  logic        s_last  [NI];
  logic        s_valid [NI];
  logic        s_ready [NI];
  logic [63:0] m_data  [NI];
  logic [7:0]  m_keep  [NI];
  logic [7:0]  m_user  [NI];
  logic        m_last  [NI];
  logic        m_valid [NI];
  logic        m_ready [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    axis_register_skid_chain #(.BYTE_WIDTH(8), .USER_WIDTH(8), .STAGES(g + 1)) u_dut (
      .CLK(clk), .RESET(rst),
      .S_AXIS_TDATA(s_data[g]), .S_AXIS_TKEEP(s_keep[g]), .S_AXIS_TUSER(s_user[g]),
      .S_AXIS_TVALID(s_valid[g]), .S_AXIS_TREADY(s_ready[g]), .S_AXIS_TLAST(s_last[g]),
      .M_AXIS_TDATA(m_data[g]), .M_AXIS_TKEEP(m_keep[g]), .M_AXIS_TUSER(m_user[g]),
      .M_AXIS_TVALID(m_valid[g]), .M_AXIS_TREADY(m_ready[g]), .M_AXIS_TLAST(m_last[g])
    );
  end

  logic [7:0] z_sdata, z_mdata;
  logic       z_skeep, z_suser, z_svalid, z_sready, z_slast;
  logic       z_mkeep, z_muser, z_mvalid, z_mready, z_mlast;

  axis_register_skid_chain #(.BYTE_WIDTH(1), .USER_WIDTH(0), .STAGES(0)) u_byp (
    .CLK(clk), .RESET(rst),
    .S_AXIS_TDATA(z_sdata), .S_AXIS_TKEEP(z_skeep), .S_AXIS_TUSER(z_suser),
    .S_AXIS_TVALID(z_svalid), .S_AXIS_TREADY(z_sready), .S_AXIS_TLAST(z_slast),
    .M_AXIS_TDATA(z_mdata), .M_AXIS_TKEEP(z_mkeep), .M_AXIS_TUSER(z_muser),
    .M_AXIS_TVALID(z_mvalid), .M_AXIS_TREADY(z_mready), .M_AXIS_TLAST(z_mlast)
  );

  int          n_cmp;
  int          n_fail;
  int          seq        [NI];
  int          n_acc      [NI];
  int          n_out      [NI];
  logic        stall_prev [NI];
  logic [80:0] held       [NI];
  logic [80:0] q [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat n: data = {~n, n}, keep/user derived from n, TLAST on every 7th beat.
  function automatic logic [80:0] mk_beat(input int n);
    logic [31:0] u;
    u = n;
    return {~u, u, u[7:0] ^ 8'h3C, u[15:8] ^ 8'hA5, ((n % 7) == 6)};
  endfunction

  task automatic drive(input int i);
    logic [80:0] b;
    b = mk_beat(seq[i]);
    s_data[i] = b[80:17];
    s_keep[i] = b[16:9];
    s_user[i] = b[8:1];
    s_last[i] = b[0];
  endtask

  task automatic clr(input int i);
    q.delete();
    n_acc[i]      = 0;
    n_out[i]      = 0;
    stall_prev[i] = 1'b0;
  endtask

  // One clock of instance i: entered at a negedge with inputs set; scores the
  // handshakes that will occur at the coming posedge, returns at next negedge.
  task automatic cyc(input int i);
    logic        sf, mf;
    logic [80:0] mb, ex;
    #1;
    sf = s_valid[i] & s_ready[i];
    mf = m_valid[i] & m_ready[i];
    mb = {m_data[i], m_keep[i], m_user[i], m_last[i]};
    if (stall_prev[i]) begin
      chk("stall_valid", m_valid[i], 1'b1);
      chk("stall_beat", mb, held[i]);
    end
    if (mf) begin
      ex = (q.size() > 0) ? q.pop_front() : 81'bx;
      chk("beat_order", mb, ex);
      n_out[i]++;
    end
    if (sf) q.push_back(mk_beat(seq[i]));
    stall_prev[i] = m_valid[i] & ~m_ready[i] & ~rst;
    held[i]       = mb;
    @(posedge clk);
    @(negedge clk);
    if (sf) begin
      seq[i]++;
      n_acc[i]++;
      drive(i);
    end
  endtask

  task automatic drain(input int i, input string tag);
    s_valid[i] = 1'b0;
    m_ready[i] = 1'b1;
    for (int k = 0; k < 48; k++) begin
      if (q.size() == 0) break;
      cyc(i);
    end
    #1;
    chk({tag, "_drain_empty"}, q.size(), 0);
    chk({tag, "_count"}, n_out[i], n_acc[i]);
    chk({tag, "_idle"}, m_valid[i], 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      s_valid[i] = 1'b0;
      m_ready[i] = 1'b0;
      seq[i]     = 0;
      held[i]    = '0;
      clr(i);
      drive(i);
    end
    z_sdata = 8'h00; z_skeep = 1'b0; z_suser = 1'b0;
    z_svalid = 1'b0; z_slast = 1'b0; z_mready = 1'b0;

    // Reset held: no handshakes anywhere.
    @(posedge clk); @(posedge clk); @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_sready", s_ready[i], 1'b0);
      chk("rst_mvalid", m_valid[i], 1'b0);
    end

    // Pass-through chain follows its inputs even while reset is high.
    for (int k = 0; k < 6; k++) begin
      logic [31:0] v;
      v = 32'h9E37_79B9 * (k + 1);
      z_sdata = v[7:0]; z_skeep = v[8]; z_suser = 1'b1;
      z_svalid = v[9]; z_slast = v[10]; z_mready = v[11];
      #2;
      chk("byp_data", z_mdata, v[7:0]);
      chk("byp_keep", z_mkeep, v[8]);
      chk("byp_valid", z_mvalid, v[9]);
      chk("byp_last", z_mlast, v[10]);
      chk("byp_ready", z_sready, v[11]);
      chk("byp_user", z_muser, 1'b0);
    end

    // Release: one more cycle with both handshakes low, then empty.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_sready", s_ready[0], 1'b0);
    chk("rel_mvalid", m_valid[0], 1'b0);
    @(posedge clk); @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("empty_sready", s_ready[i], 1'b1);
      chk("empty_mvalid", m_valid[i], 1'b0);
    end

    // STAGES=3, ready high: beats 1..10 emerge from cycle 3, one per cycle.
    seq[2] = 1;
    drive(2);
    m_ready[2] = 1'b1;
    for (int c = 0; c < 13; c++) begin
      s_valid[2] = (c < 10);
      #1;
      if (c < 10) chk("t25_sready", s_ready[2], 1'b1);
      chk("t25_mvalid", m_valid[2], (c >= 3));
      if (c >= 3) chk("t25_data", m_data[2][7:0], c - 2);
      cyc(2);
    end
    drain(2, "t25");

    // STAGES=2, ready low: four beats fill the chain, then resume.
    m_ready[1] = 1'b0;
    s_valid[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t26_sready", s_ready[1], (c < 4));
      cyc(1);
    end
    chk("t26_accepted", n_acc[1], 4);
    m_ready[1] = 1'b1;
    begin
      int base;
      base = n_out[1];
      for (int c = 0; c < 12; c++) cyc(1);
      chk("t26_resume", n_out[1] - base, 12);
    end
    drain(1, "t26");

    // STAGES=1, ready toggling every cycle, random valid.
    for (int c = 0; c < 300; c++) begin
      m_ready[0] = ((c % 2) == 0);
      s_valid[0] = ($urandom_range(1) != 0);
      cyc(0);
    end
    drain(0, "t27");

    // STAGES=4: six beats held, reset pulse discards them.
    m_ready[3] = 1'b0;
    s_valid[3] = 1'b1;
    for (int c = 0; c < 6; c++) cyc(3);
    chk("t28_held", n_acc[3], 6);
    s_valid[3] = 1'b0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    clr(3);
    #1;
    chk("t28_mvalid_post", m_valid[3], 1'b0);
    chk("t28_sready_post", s_ready[3], 1'b0);
    cyc(3);
    #1;
    chk("t28_sready_back", s_ready[3], 1'b1);
    chk("t28_mvalid_back", m_valid[3], 1'b0);
    m_ready[3] = 1'b1;
    s_valid[3] = 1'b1;
    for (int c = 0; c < 10; c++) cyc(3);
    drain(3, "t28");

    // Random valid/ready soak on STAGES 1, 2 and 5.
    for (int t = 0; t < 3; t++) begin
      int i;
      i = (t == 0) ? 0 : ((t == 1) ? 1 : 4);
      clr(i);
      for (int c = 0; c < 20000 && n_acc[i] < 3400; c++) begin
        s_valid[i] = ($urandom_range(3) != 0);
        m_ready[i] = ($urandom_range(3) != 0);
        cyc(i);
      end
      chk("t30_beats", n_acc[i], 3400);
      drain(i, "t30");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
